// File: rtl/elastic_pkg.sv
// Shared types and limits for the elastic pipeline register and its skid slots.
package elastic_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } slot_state_e;

endpackage

// File: rtl/elastic_slot.sv
// One 2-entry skid slot: main register drives the output, skid catches the item
// accepted while the consumer stalls, so in_ready can come straight from a flop.
module elastic_slot
  import elastic_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  slot_state_e      state_q, state_d;
  logic             rdy_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;

  assign accept = in_valid & rdy_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (accept && !out_ready) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (accept && out_ready) begin
          load_main = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d        = BUSY;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over every handshake; data registers are left untouched.
    if (flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      main_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
      if (load_main)           main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= in_data;
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready pipeline register built from STAGES cascaded skid slots.
// Optional stall counter output enabled by defining ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe_reg
  import elastic_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("elastic_pipe_reg: STAGES must be within 1..%0d", MAX_STAGES);
  end

  // Index k is the input side of slot k; index STAGES is the block output.
  logic             vld [0:STAGES];
  logic             rdy [0:STAGES];
  logic [WIDTH-1:0] dat [0:STAGES];

  assign vld[0]      = in_valid;
  assign dat[0]      = in_data;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];
  assign out_data    = dat[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    elastic_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_data   (dat[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_data  (dat[k+1])
    );
  end

`ifdef ELASTIC_PIPE_STALL_CNT_EN
  // Saturating count of cycles the head item waits on the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg; instances with STAGES = 1, 2 and 3.
// Covers the stall counter when ELASTIC_PIPE_STALL_CNT_EN is defined.
module tb_elastic_pipe_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        iv   [1:3];
  logic        ir   [1:3];
  logic [31:0] id   [1:3];
  logic        ov   [1:3];
  logic        ordy [1:3];
  logic [31:0] od   [1:3];
  logic [31:0] sc   [1:3];

  int n_cmp;
  int n_bad;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    elastic_pipe_reg #(
      .WIDTH     (32),
      .STAGES    (g),
      .RESET_VAL (RV)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (id[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g])
`ifdef ELASTIC_PIPE_STALL_CNT_EN
      ,
      .stall_cnt (sc[g])
`endif
    );
`ifndef ELASTIC_PIPE_STALL_CNT_EN
    assign sc[g] = '0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ir[2] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%0b exp=0", ir[2]); end
    n_cmp++; if (ov[2] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b exp=0", ov[2]); end
    n_cmp++; if (od[2] !== RV) begin n_bad++; $display("FAIL reset_out_data got=%h exp=%h", od[2], RV); end
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (ir[2] !== 1'b0) begin n_bad++; $display("FAIL release_in_ready_early got=%0b exp=0", ir[2]); end
    tick();
    n_cmp++; if (ir[2] !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%0b exp=1", ir[2]); end
    // Load three items with the consumer stalled, then reset mid-stream.
    ordy[2] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      iv[2] = 1'b1; id[2] = i;
      tick();
    end
    iv[2] = 1'b0;
    n_cmp++; if (ov[2] !== 1'b1 || od[2] !== 32'd1) begin n_bad++; $display("FAIL held_head got=%0b/%h exp=1/1", ov[2], od[2]); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ov[2] !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid got=%0b exp=0", ov[2]); end
    n_cmp++; if (od[2] !== RV) begin n_bad++; $display("FAIL midreset_out_data got=%h exp=%h", od[2], RV); end
    n_cmp++; if (ir[2] !== 1'b0) begin n_bad++; $display("FAIL midreset_in_ready got=%0b exp=0", ir[2]); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (ir[2] !== 1'b0) begin n_bad++; $display("FAIL midrelease_in_ready_early got=%0b exp=0", ir[2]); end
    tick();
    n_cmp++; if (ir[2] !== 1'b1 || ov[2] !== 1'b0) begin n_bad++; $display("FAIL midrelease_state got=%0b/%0b exp=1/0", ir[2], ov[2]); end
  endtask

  task automatic test_streaming();
    ordy[2] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      iv[2] = (k < 16);
      id[2] = k + 1;
      tick();
      n_cmp++; if (ov[2] !== (k >= 1 && k <= 16)) begin n_bad++; $display("FAIL stream_valid k=%0d got=%0b exp=%0b", k, ov[2], (k >= 1 && k <= 16)); end
      if (k >= 1 && k <= 16) begin
        n_cmp++; if (od[2] !== k) begin n_bad++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, od[2], k); end
      end
      n_cmp++; if (ir[2] !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready k=%0d got=%0b exp=1", k, ir[2]); end
    end
    iv[2] = 1'b0;
    ordy[2] = 1'b0;
  endtask

  task automatic test_back_pressure();
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 32'hA;
    tick();
    n_cmp++; if (ir[1] !== 1'b1 || ov[1] !== 1'b1 || od[1] !== 32'hA) begin n_bad++; $display("FAIL bp_first got=%0b/%0b/%h exp=1/1/a", ir[1], ov[1], od[1]); end
    id[1] = 32'hB;
    tick();
    iv[1] = 1'b0;
    n_cmp++; if (ir[1] !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready got=%0b exp=0", ir[1]); end
    n_cmp++; if (od[1] !== 32'hA) begin n_bad++; $display("FAIL bp_head got=%h exp=a", od[1]); end
    tick();
    n_cmp++; if (ov[1] !== 1'b1 || od[1] !== 32'hA) begin n_bad++; $display("FAIL bp_stable got=%0b/%h exp=1/a", ov[1], od[1]); end
    ordy[1] = 1'b1;
    tick();
    n_cmp++; if (ov[1] !== 1'b1 || od[1] !== 32'hB) begin n_bad++; $display("FAIL bp_second got=%0b/%h exp=1/b", ov[1], od[1]); end
    n_cmp++; if (ir[1] !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_after_pop got=%0b exp=1", ir[1]); end
    tick();
    n_cmp++; if (ov[1] !== 1'b0) begin n_bad++; $display("FAIL bp_drained got=%0b exp=0", ov[1]); end
    ordy[1] = 1'b0;
  endtask

  task automatic test_capacity();
    int  n_acc;
    int  got;
    logic acc;
    n_acc = 0;
    ordy[3] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      iv[3] = 1'b1;
      id[3] = 32'h100 + n_acc;
      acc = ir[3];
      tick();
      if (acc) n_acc++;
    end
    iv[3] = 1'b0;
    n_cmp++; if (n_acc !== 6) begin n_bad++; $display("FAIL cap_accepts got=%0d exp=6", n_acc); end
    n_cmp++; if (ir[3] !== 1'b0) begin n_bad++; $display("FAIL cap_in_ready got=%0b exp=0", ir[3]); end
    got = 0;
    ordy[3] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (ov[3]) begin
        n_cmp++; if (od[3] !== 32'h100 + got) begin n_bad++; $display("FAIL cap_order idx=%0d got=%h exp=%h", got, od[3], 32'h100 + got); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL cap_drain_count got=%0d exp=6", got); end
    n_cmp++; if (ov[3] !== 1'b0 || ir[3] !== 1'b1) begin n_bad++; $display("FAIL cap_empty got=%0b/%0b exp=0/1", ov[3], ir[3]); end
    ordy[3] = 1'b0;
  endtask

  task automatic test_flush();
    int   n2, n3;
    logic a2, a3;
    n2 = 0; n3 = 0;
    ordy[2] = 1'b0; ordy[3] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      iv[2] = (n2 < 4); id[2] = 32'h41 + n2;
      iv[3] = (n3 < 4); id[3] = 32'h41 + n3;
      a2 = iv[2] & ir[2];
      a3 = iv[3] & ir[3];
      tick();
      if (a2) n2++;
      if (a3) n3++;
    end
    n_cmp++; if (n2 !== 4 || n3 !== 4) begin n_bad++; $display("FAIL flush_fill got=%0d/%0d exp=4/4", n2, n3); end
    n_cmp++; if (ir[2] !== 1'b0 || ir[3] !== 1'b1) begin n_bad++; $display("FAIL flush_pre_ready got=%0b/%0b exp=0/1", ir[2], ir[3]); end
    n_cmp++; if (ov[3] !== 1'b1 || od[3] !== 32'h41) begin n_bad++; $display("FAIL flush_pre_head got=%0b/%h exp=1/41", ov[3], od[3]); end
    flush = 1'b1;
    iv[2] = 1'b1; id[2] = 32'h55;
    iv[3] = 1'b1; id[3] = 32'h55;
    tick();
    flush = 1'b0;
    iv[2] = 1'b0; iv[3] = 1'b0;
    n_cmp++; if (ov[2] !== 1'b0 || ov[3] !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got=%0b/%0b exp=0/0", ov[2], ov[3]); end
    n_cmp++; if (ir[2] !== 1'b1 || ir[3] !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got=%0b/%0b exp=1/1", ir[2], ir[3]); end
    n_cmp++; if (od[2] !== 32'h41 || od[3] !== 32'h41) begin n_bad++; $display("FAIL flush_data_hold got=%h/%h exp=41/41", od[2], od[3]); end
    ordy[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (ov[3] !== 1'b0) begin n_bad++; $display("FAIL flush_discard c=%0d got=%0b/%h exp=0", c, ov[3], od[3]); end
    end
    iv[3] = 1'b1; id[3] = 32'h66;
    tick();
    iv[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      n_cmp++; if (ov[3] !== (k == 2)) begin n_bad++; $display("FAIL flush_refill_valid k=%0d got=%0b exp=%0b", k, ov[3], (k == 2)); end
    end
    n_cmp++; if (od[3] !== 32'h66) begin n_bad++; $display("FAIL flush_refill_data got=%h exp=66", od[3]); end
    tick();
    n_cmp++; if (ov[3] !== 1'b0) begin n_bad++; $display("FAIL flush_refill_drain got=%0b exp=0", ov[3]); end
    ordy[3] = 1'b0;
  endtask

`ifdef ELASTIC_PIPE_STALL_CNT_EN
  task automatic test_stall_cnt();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 32'h77;
    tick();
    iv[1] = 1'b0;
    n_cmp++; if (sc[1] !== 32'd0) begin n_bad++; $display("FAIL stall_start got=%0d exp=0", sc[1]); end
    repeat (10) tick();
    n_cmp++; if (sc[1] !== 32'd10) begin n_bad++; $display("FAIL stall_ten got=%0d exp=10", sc[1]); end
    ordy[1] = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ordy[1] = 1'b0;
    n_cmp++; if (sc[1] !== 32'd10 || ov[1] !== 1'b0) begin n_bad++; $display("FAIL stall_flush got=%0d/%0b exp=10/0", sc[1], ov[1]); end
    tick();
    n_cmp++; if (sc[1] !== 32'd10) begin n_bad++; $display("FAIL stall_idle got=%0d exp=10", sc[1]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (sc[1] !== 32'd0) begin n_bad++; $display("FAIL stall_rst got=%0d exp=0", sc[1]); end
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    flush = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      iv[g] = 1'b0; id[g] = '0; ordy[g] = 1'b0;
    end
    test_reset();
    test_streaming();
    test_back_pressure();
    test_capacity();
    test_flush();
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
